// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding and
// default timing parameters.
package keypad_pkg;

    localparam int DWELL_DEFAULT    = 100000;
    localparam int DB_TICKS_DEFAULT = 20;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

endpackage

// File: rtl/keypad_tick.sv
// Free-running dwell counter; tick marks the last cycle of every column dwell.
module keypad_tick
    import keypad_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: walks an active-low column strobe, debounces the first
// key found, reports it once on key_valid and holds key_held until release.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DWELL    = DWELL_DEFAULT,
    parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output state_t     dbg_state
);

    localparam int             DBW     = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);

    logic [3:0]     row_meta;
    logic [3:0]     row_sync;
    logic           tick;

    state_t         state,     state_n;
    logic [1:0]     col_idx,   col_idx_n;
    logic [1:0]     row_idx,   row_idx_n;
    logic [DBW-1:0] db_cnt,    db_cnt_n;
    logic [3:0]     code_n;
    logic           valid_n;

    logic           any_low;
    logic [1:0]     low_idx;
    logic           latched_low;
    logic           db_done;

    keypad_tick #(
        .DWELL (DWELL)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign any_low     = ~&row_sync;
    assign latched_low = ~row_sync[row_idx];
    // The count about to be written reaches the last debounce step.
    assign db_done     = (int'(db_cnt) + 1 >= DB_TICKS - 1);

    always_comb begin
        low_idx = 2'd3;
        if (!row_sync[2]) low_idx = 2'd2;
        if (!row_sync[1]) low_idx = 2'd1;
        if (!row_sync[0]) low_idx = 2'd0;
    end

    always_comb begin
        state_n   = state;
        col_idx_n = col_idx;
        row_idx_n = row_idx;
        db_cnt_n  = db_cnt;
        code_n    = key_code;
        valid_n   = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        row_idx_n = low_idx;
                        db_cnt_n  = '0;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (latched_low) begin
                        if (db_done) begin
                            db_cnt_n = DB_LAST;
                            state_n  = HELD;
                            valid_n  = 1'b1;
                            code_n   = {row_idx, col_idx};
                        end else begin
                            db_cnt_n = db_cnt + 1'b1;
                        end
                    end else begin
                        state_n   = SCAN;
                        col_idx_n = col_idx + 2'd1;
                    end
                end
                HELD: begin
                    if (!latched_low) begin
                        db_cnt_n = '0;
                        state_n  = RELEASE;
                    end
                end
                RELEASE: begin
                    if (latched_low) begin
                        state_n = HELD;
                    end else if (db_done) begin
                        db_cnt_n  = DB_LAST;
                        state_n   = SCAN;
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        db_cnt_n = db_cnt + 1'b1;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            db_cnt    <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_idx_n;
            row_idx   <= row_idx_n;
            db_cnt    <= db_cnt_n;
            key_code  <= code_n;
            key_valid <= valid_n;
        end
    end

    assign col       = ~(4'b0001 << col_idx);
    assign key_held  = (state == HELD) || (state == RELEASE);
    assign dbg_state = state;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a key-matrix environment drives row from col, and a
// tick-level reference model predicts every output cycle by cycle.
module tb_keypad_scan;
    import keypad_pkg::*;

    localparam int DWELL    = 4;
    localparam int DB_TICKS = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    state_t     dbg_state;

    // keys[r][c] = 1 means the switch joining row r and column c is closed
    logic [3:0] keys [4];

    int total = 0;
    int bad   = 0;

    // reference model
    int         m_cnt;
    logic [3:0] m_h1, m_h2;
    int         m_col, m_row;
    bit         m_busy, m_acc;
    int         m_good, m_rel;
    logic [3:0] m_code;
    bit         m_valid;

    logic [3:0] exp_q[$];
    int         n_valid;
    int         n_held_fall;
    logic       prev_held;

    keypad_scan #(
        .DWELL    (DWELL),
        .DB_TICKS (DB_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) row[r] = ~|(keys[r] & ~col);
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_h1   = 4'hF;
        m_h2   = 4'hF;
        m_col  = 0;
        m_row  = 0;
        m_busy = 0;
        m_acc  = 0;
        m_good = 0;
        m_rel  = 0;
        m_code = 4'h0;
        m_valid = 0;
        exp_q.delete();
    endtask

    // One clock edge of the keypad rules: rows are seen two edges late and
    // only every DWELL-th edge counts.
    task automatic model_edge(input logic [3:0] rv);
        logic [3:0] sr;
        bit         tick;
        bit         lowbit;
        m_valid = 0;
        sr   = m_h2;
        m_h2 = m_h1;
        m_h1 = rv;
        tick  = (m_cnt == DWELL - 1);
        m_cnt = (m_cnt + 1) % DWELL;
        if (tick) begin
            if (!m_busy) begin
                if (sr != 4'hF) begin
                    m_busy = 1;
                    m_good = 1;
                    for (int i = 3; i >= 0; i--) if (!sr[i]) m_row = i;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else begin
                lowbit = !sr[m_row];
                if (!m_acc) begin
                    if (lowbit) begin
                        m_good++;
                        if (m_good == DB_TICKS) begin
                            m_acc   = 1;
                            m_rel   = 0;
                            m_valid = 1;
                            m_code  = 4'(m_row * 4 + m_col);
                            exp_q.push_back(m_code);
                        end
                    end else begin
                        m_busy = 0;
                        m_col  = (m_col + 1) % 4;
                    end
                end else if (lowbit) begin
                    m_rel = 0;
                end else begin
                    m_rel++;
                    if (m_rel == DB_TICKS) begin
                        m_busy = 0;
                        m_acc  = 0;
                        m_col  = (m_col + 1) % 4;
                    end
                end
            end
        end
    endtask

    // driver: one clock, starting and ending just after a falling edge
    task automatic cycle();
        logic [3:0] rv;
        logic [3:0] got_code;
        #1 rv = row;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_edge(rv);
        check("col", col, 4'(~(32'd1 << m_col)));
        check("key_valid", 4'(key_valid), 4'(m_valid));
        check("key_held", 4'(key_held), 4'(m_acc));
        check("key_code", key_code, m_code);
        if (key_valid) begin
            n_valid++;
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL sb_unexpected got=%h exp=none", key_code);
            end
            if (exp_q.size() > 0) begin
                got_code = exp_q.pop_front();
                check("sb_code", key_code, got_code);
            end
        end
        if (prev_held && !key_held) n_held_fall++;
        prev_held = key_held;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) keys[r] = 4'h0;
    endtask

    task automatic wait_col(input logic [3:0] target);
        logic [3:0] prev;
        int         n;
        prev = col;
        n = 0;
        while (!(col == target && prev != target) && n < 64) begin
            prev = col;
            cycle();
            n++;
        end
        check("wait_col", col, target);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_col", col, 4'b1110);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", 4'(key_valid), 4'h0);
        check("rst_key_held", 4'(key_held), 4'h0);
        model_reset();
        clear_keys();
        run(3);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int r;
        int c;
        rst = 1'b1;
        clear_keys();
        model_reset();
        prev_held = 1'b0;
        n_valid = 0;
        n_held_fall = 0;
        @(negedge clk);
        check("reset_col", col, 4'b1110);
        check("reset_key_code", key_code, 4'h0);
        check("reset_key_valid", 4'(key_valid), 4'h0);
        check("reset_key_held", 4'(key_held), 4'h0);
        run(2);
        rst = 1'b0;

        // idle scan
        n_valid = 0;
        run(32);
        check("idle_pulses", 4'(n_valid), 4'd0);

        // clean press on row 2 / column 1
        n_valid = 0;
        wait_col(4'b1101);
        keys[2][1] = 1'b1;
        run(40);
        check("clean_held", 4'(key_held), 4'd1);
        keys[2][1] = 1'b0;
        run(24);
        check("clean_pulses", 4'(n_valid), 4'd1);
        check("clean_code", key_code, 4'b1001);
        check("clean_released", 4'(key_held), 4'd0);

        // single-tick bounce on row 0 / column 0
        n_valid = 0;
        wait_col(4'b1110);
        keys[0][0] = 1'b1;
        run(4);
        keys[0][0] = 1'b0;
        run(4);
        check("bounce_col", col, 4'b1101);
        run(8);
        check("bounce_pulses", 4'(n_valid), 4'd0);

        // two rows on column 3: lowest row wins, no second pulse
        n_valid = 0;
        wait_col(4'b0111);
        keys[1][3] = 1'b1;
        keys[3][3] = 1'b1;
        run(40);
        keys[3][3] = 1'b0;
        run(20);
        keys[1][3] = 1'b0;
        run(30);
        check("two_row_pulses", 4'(n_valid), 4'd1);
        check("two_row_code", key_code, 4'b0111);

        // release bounce while held
        n_valid = 0;
        n_held_fall = 0;
        wait_col(4'b1011);
        keys[3][2] = 1'b1;
        run(40);
        keys[3][2] = 1'b0;
        run(4);
        keys[3][2] = 1'b1;
        run(30);
        keys[3][2] = 1'b0;
        run(30);
        check("relb_pulses", 4'(n_valid), 4'd1);
        check("relb_held_falls", 4'(n_held_fall), 4'd1);
        check("relb_code", key_code, 4'b1110);

        // reset during debounce
        n_valid = 0;
        wait_col(4'b1101);
        keys[0][1] = 1'b1;
        n = 0;
        while (!(m_busy && !m_acc) && n < 40) begin
            cycle();
            n++;
        end
        check("reach_debounce", 4'(m_busy && !m_acc), 4'd1);
        apply_reset();
        run(20);
        check("rst_mid_pulses", 4'(n_valid), 4'd0);

        // randomized presses, durations and extra keys
        for (int it = 0; it < 10; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            keys[r][c] = 1'b1;
            if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            run($urandom_range(1, 48));
            clear_keys();
            run($urandom_range(16, 40));
        end
        run(30);
        check("sb_drain", 4'(exp_q.size()), 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
